pipe_ctrl: RTL
==============

# pipe_ctrl

Pipeline stall/flush controller for the five-stage core. It drives the stall vector consumed by the PC register and every inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB), and sequences multi-cycle EX operations with an internal down-counter. It also issues the pipeline flush and redirect PC on exception. All pipeline registers take their hold/bubble decisions solely from this block.

## Interface

Parameters:
- CNT_W, 6, width of multi-cycle length/counter (max op length 2^CNT_W−1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset rst, synchronous, active-high
- stallreq_id  in  1  load-use hazard from ID, same-cycle request
- mc_start  in  1  EX holds a multi-cycle op (asserted every cycle the op sits in EX)
- mc_len  in  CNT_W  total EX cycles for the op, sampled on accepted mc_start
- flush_req  in  1  exception detected in MEM
- flush_pc  in  32  exception handler address
- stall  out  6  [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB, [5] reserved (0)
- flush  out  1  clear all pipeline registers to reset/NOP values this edge
- new_pc  out  32  redirect target, valid when flush=1, else 0
- mc_busy  out  1  multi-cycle sequence in progress (state BUSY)
- mc_done  out  1  final EX cycle of multi-cycle op; EX presents result
- stall_cnt  out  32  saturating count of cycles with stall≠0

## Operation

- Stall rule for consumers: stall[i]=1 and stall[i+1]=1 → hold; stall[i]=1 and stall[i+1]=0 → load NOP bubble (reset values); else advance.
- FSM states: IDLE, BUSY. Counter cnt (CNT_W bits).
- Priority per cycle: flush_req > multi-cycle > stallreq_id > none.
- flush_req=1: flush=1, new_pc=flush_pc, stall=000000, state→IDLE, cnt→0, mc_done=0.
- IDLE, mc_start=1: accept; stall=001111; cnt←max(mc_len,2)−1; state→BUSY. mc_len 0 or 1 treated as 2.
- BUSY, cnt>1: stall=001111; cnt←cnt−1; mc_start ignored.
- BUSY, cnt==1: mc_done=1; EX released (stall[3]=0); state→IDLE; cnt→0. If stallreq_id=1 same cycle, stall=000111, else 000000.
- mc_start in the cycle after done belongs to the next op and is accepted normally.
- No multi-cycle activity, stallreq_id=1: stall=000111 (bubble into ID/EX).
- stallreq_id during BUSY with cnt>1: subsumed by 001111.
- stall_cnt increments each cycle stall≠0, saturates at 0xFFFFFFFF; not cleared by flush.

## Timing

- stall, flush, new_pc, mc_done: combinational from state/cnt and same-cycle inputs; zero latency.
- mc_busy, stall_cnt, state, cnt: registered.
- A multi-cycle op of length N occupies EX exactly N cycles: accept cycle + N−1 BUSY cycles; mc_done on the Nth.
- Reset: state=IDLE, cnt=0, stall_cnt=0; while rst=1 all outputs 0 (stall=000000, flush=0, new_pc=0, mc_busy=0, mc_done=0).
- rst during BUSY: next cycle IDLE; partial op discarded.
- flush_req in the same cycle as mc_done: flush wins, mc_done=0.

## Structure

- define.v holds: StallBus (5:0), stall constants StallNone=6'b000000, StallId=6'b000111, StallEx=6'b001111, FSM state encodings, CNT_W default.
- One sub-module: mc_timer (load/decrement counter with done flag), instantiated once; FSM, priority mux and stall_cnt stay in pipe_ctrl.

## Test plan

- stallreq_id=1 for 1 cycle, no other request → stall=000111 that cycle, 000000 next; stall_cnt=1.
- mc_start with mc_len=5, held until done → stall=001111 for 4 cycles, mc_done=1 with stall=000000 on cycle 5, mc_busy=1 cycles 2–5.
- mc_len=0 and mc_len=1 → behave as 2: one stall cycle, mc_done on second.
- flush_req with flush_pc=0x00000040 on BUSY cycle 3 of a length-8 op → flush=1, new_pc=0x40, stall=0, next cycle mc_busy=0, mc_done never asserts.
- mc_done cycle with stallreq_id=1 → stall=000111, mc_done=1; back-to-back mc_start next cycle accepted.
- rst mid-BUSY, then release → all outputs 0, stall_cnt=0, next mc_start accepted from IDLE.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  localparam int unsigned CNT_W_DEF = 6;
  localparam int unsigned STALL_W   = 6;
  localparam int unsigned PC_W      = 32;
  localparam int unsigned SCNT_W    = 32;

  // Bit i holds stage i; a set bit with a clear bit above it inserts a bubble.
  typedef logic [STALL_W-1:0] stall_bus_t;

  localparam stall_bus_t STALL_NONE = 6'b000000;
  localparam stall_bus_t STALL_ID   = 6'b000111;
  localparam stall_bus_t STALL_EX   = 6'b001111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/pipe_ctrl_mc_timer.sv
// Load/decrement counter sequencing a multi-cycle EX op; done flags the last cycle.
module mc_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: priority flush > multi-cycle EX > load-use stall.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallreq_id,
  input  logic                mc_start,
  input  logic [CNT_W-1:0]    mc_len,
  input  logic                flush_req,
  input  logic [PC_W-1:0]     flush_pc,
  output logic [STALL_W-1:0]  stall,
  output logic                flush,
  output logic [PC_W-1:0]     new_pc,
  output logic                mc_busy,
  output logic                mc_done,
  output logic [SCNT_W-1:0]   stall_cnt
);

  state_e            state_q;
  state_e            state_d;
  logic [SCNT_W-1:0] stall_cnt_q;
  logic [SCNT_W-1:0] stall_cnt_d;

  logic              tmr_clr;
  logic              tmr_load;
  logic              tmr_dec;
  logic [CNT_W-1:0]  tmr_load_val;
  logic [CNT_W-1:0]  tmr_cnt;
  logic              tmr_done;

  mc_timer #(.CNT_W(CNT_W)) u_mc_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmr_clr),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .cnt      (tmr_cnt),
    .done     (tmr_done)
  );

  // Lengths 0 and 1 are stretched to 2 so every op gets at least one BUSY cycle.
  assign tmr_load_val = (mc_len < CNT_W'(2)) ? CNT_W'(1) : (mc_len - CNT_W'(1));

  always_comb begin
    state_d  = state_q;
    stall    = STALL_NONE;
    flush    = 1'b0;
    new_pc   = '0;
    mc_done  = 1'b0;
    tmr_clr  = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    if (rst) begin
      state_d = ST_IDLE;
    end else if (flush_req) begin
      flush   = 1'b1;
      new_pc  = flush_pc;
      state_d = ST_IDLE;
      tmr_clr = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (mc_start) begin
            stall    = STALL_EX;
            tmr_load = 1'b1;
            state_d  = ST_BUSY;
          end else if (stallreq_id) begin
            stall = STALL_ID;
          end
        end
        ST_BUSY: begin
          tmr_dec = 1'b1;
          if (tmr_done) begin
            mc_done = 1'b1;
            state_d = ST_IDLE;
            stall   = stallreq_id ? STALL_ID : STALL_NONE;
          end else begin
            stall = STALL_EX;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((stall != STALL_NONE) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + SCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mc_busy   = !rst && (state_q == ST_BUSY);
  assign stall_cnt = stall_cnt_q;

  logic unused_cnt;
  assign unused_cnt = ^tmr_cnt;

endmodule
